// File: rtl/pc_branch_unit.sv
// Fetch program counter with PC-relative redirects, stall hold and a one-cycle
// fetch bubble plus flush pulse after every accepted redirect.
module pc_branch_unit #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter int                 INC      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             misalign,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;

    logic             fetching;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;

    // Redirects are only accepted while a real fetch address is presented.
    assign fetching = (state_q == RUN) || (state_q == HOLD);
    assign redirect = fetching && br_valid && br_taken;
    assign target   = pc_q + offset;
    assign pc_inc   = pc_q + INC_W;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            BOOT: begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN, HOLD: begin
                if (redirect) begin
                    state_d    = BUBBLE;
                    pc_d       = target;
                    pc_valid_d = 1'b0;
                    flush_d    = 1'b1;
                    misalign_d = target[0];
                end else if (stall) begin
                    state_d    = HOLD;
                    pc_valid_d = 1'b1;
                end else begin
                    state_d    = RUN;
                    pc_d       = pc_inc;
                    pc_valid_d = 1'b1;
                end
            end
            BUBBLE: begin
                // The target is already in pc; it becomes a real fetch now.
                state_d    = stall ? HOLD : RUN;
                pc_valid_d = 1'b1;
            end
            default: begin
                state_d    = BOOT;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign misalign = misalign_q;
    assign state_o  = state_q;

endmodule
